// File: rtl/gray_conv_sched.sv
// gray_conv_sched: round-robin scheduler sharing one bit-serial Gray encode/decode engine between two requesters
module gray_conv_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_din,
    input  logic             req0_gray_n,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_din,
    input  logic             req1_gray_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Dout,
    output logic             out_id,
    output logic             out_gray_n,
    output logic             busy
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             rr_q, rr_d;
    logic             id_q, id_d;
    logic             gray_n_q, gray_n_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] din_sh, dout_sh;
    logic             grant0, grant1, bit_nxt;

    // Neighbour bit one position up; zero above the MSB so the top bit passes straight through.
    assign din_sh  = {1'b0, din_q[WIDTH-1:1]};
    assign dout_sh = {1'b0, dout_q[WIDTH-1:1]};

    // State register; reset abandons any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= IW'(WIDTH - 1);
            rr_q     <= 1'b0;
            id_q     <= 1'b0;
            gray_n_q <= 1'b0;
            din_q    <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_q     <= rr_d;
            id_q     <= id_d;
            gray_n_q <= gray_n_d;
            din_q    <= din_d;
            dout_q   <= dout_d;
        end
    end

    // Next state: latch the granted word in IDLE, emit one bit per enabled CONV cycle, hand priority over after DONE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_d     = rr_q;
        id_d     = id_q;
        gray_n_d = gray_n_q;
        din_d    = din_q;
        dout_d   = dout_q;
        bit_nxt  = din_q[idx_q] ^ (gray_n_q ? dout_sh[idx_q] : din_sh[idx_q]);
        case (state_q)
            IDLE: if (grant0 || grant1) begin
                state_d  = CONV;
                idx_d    = IW'(WIDTH - 1);
                id_d     = grant1;
                din_d    = grant1 ? req1_din : req0_din;
                gray_n_d = grant1 ? req1_gray_n : req0_gray_n;
                dout_d   = '0;
            end
            CONV: if (EN) begin
                dout_d[idx_q] = bit_nxt;
                state_d       = (idx_q == '0) ? DONE : CONV;
                idx_d         = (idx_q == '0) ? idx_q : idx_q - IW'(1);
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
                rr_d    = ~id_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grants are offered only in IDLE with EN high, never during reset, and never depend on out_ready.
    always_comb begin
        grant0     = rst_n && EN && (state_q == IDLE) && req0_valid && (!req1_valid || !rr_q);
        grant1     = rst_n && EN && (state_q == IDLE) && req1_valid && (!req0_valid || rr_q);
        req0_ready = grant0;
        req1_ready = grant1;
        out_valid  = (state_q == DONE);
        busy       = (state_q != IDLE);
        Dout       = dout_q;
        out_id     = id_q;
        out_gray_n = gray_n_q;
    end
endmodule

// File: tb/tb_gray_conv_sched.sv
// tb_gray_conv_sched: randomized and directed checks of gray_conv_sched against a transaction-level model
module tb_gray_conv_sched;
    localparam int W = 4;

    logic         clk = 0, rst_n = 0, EN = 0, out_ready = 0;
    logic         req0_valid = 0, req1_valid = 0, req0_gray_n = 0, req1_gray_n = 0;
    logic [W-1:0] req0_din = '0, req1_din = '0;
    logic         req0_ready, req1_ready, out_valid, out_id, out_gray_n, busy;
    logic [W-1:0] Dout;

    int           n_chk = 0, n_fail = 0;
    int           m_ph = 0, rem = 0, words = 0, cyc = 0, acc_cyc = 0, last_lat = 0;
    bit           m_rr = 0, exp_id = 0, exp_m = 0, obs_id = 0;
    logic [W-1:0] exp_d = '0, obs_dout = '0;
    int           grants[$];

    always #5 clk = ~clk;

    gray_conv_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .EN(EN),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_din(req0_din), .req0_gray_n(req0_gray_n),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_din(req1_din), .req1_gray_n(req1_gray_n),
        .out_valid(out_valid), .out_ready(out_ready), .Dout(Dout), .out_id(out_id),
        .out_gray_n(out_gray_n), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] enc(input logic [W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [W-1:0] dec(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = ^(x >> i);
        return r;
    endfunction

    // Transaction-level model: idle / converting with a count of remaining enabled cycles / result waiting.
    task automatic model_step(output bit hs0, output bit hs1);
        bit g0, g1;
        logic [W-1:0] din, mask;
        hs0 = 0;
        hs1 = 0;
        if (m_ph == 0) begin
            g0 = EN && req0_valid && (!req1_valid || !m_rr);
            g1 = EN && req1_valid && (!req0_valid || m_rr);
            check("idle_ready0", req0_ready, g0);
            check("idle_ready1", req1_ready, g1);
            check("idle_out_valid", out_valid, 0);
            check("idle_busy", busy, 0);
            if (g0 || g1) begin
                din = g1 ? req1_din : req0_din;
                exp_id = g1;
                exp_m = g1 ? req1_gray_n : req0_gray_n;
                exp_d = exp_m ? dec(din) : enc(din);
                rem = W;
                m_ph = 1;
                acc_cyc = cyc;
                grants.push_back(int'(g1));
                hs0 = g0;
                hs1 = g1;
            end
        end else if (m_ph == 1) begin
            mask = W'((1 << W) - (1 << rem));
            check("conv_partial_dout", Dout, exp_d & mask);
            check("conv_ready0", req0_ready, 0);
            check("conv_ready1", req1_ready, 0);
            check("conv_out_valid", out_valid, 0);
            check("conv_busy", busy, 1);
            if (EN) rem--;
            if (rem == 0) begin
                m_ph = 2;
                last_lat = cyc + 1 - acc_cyc;
            end
        end else begin
            check("done_out_valid", out_valid, 1);
            check("done_busy", busy, 1);
            check("done_dout", Dout, exp_d);
            check("done_id", out_id, exp_id);
            check("done_mode", out_gray_n, exp_m);
            check("done_ready0", req0_ready, 0);
            check("done_ready1", req1_ready, 0);
            if (out_ready) begin
                obs_dout = Dout;
                obs_id = out_id;
                m_ph = 0;
                m_rr = !exp_id;
                words++;
            end
        end
    endtask

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic cycle();
        bit hs0, hs1;
        #1;
        model_step(hs0, hs1);
        @(posedge clk);
        #1;
        cyc++;
        if (hs0) req0_valid = 0;
        if (hs1) req1_valid = 0;
    endtask

    task automatic run_word();
        int start;
        start = words;
        for (int k = 0; k < 40 && words == start; k++) cycle();
        check("word_complete", words, start + 1);
    endtask

    task automatic model_reset();
        m_ph = 0;
        m_rr = 0;
        grants.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_dout", Dout, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_id", out_id, 0);
        check("rst_out_gray_n", out_gray_n, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
    endtask

    task automatic reset_pulse();
        rst_n = 0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1;
    endtask

    initial begin
        logic [W-1:0] e;
        int g, w0;
        EN = 1;
        out_ready = 1;
        req0_valid = 1;
        req1_valid = 1;
        #1;
        check_reset_outputs();
        req1_valid = 0;
        req0_din = 4'b1011;
        req0_gray_n = 0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1;
        run_word();
        check("tp1_dout", obs_dout, 4'b1110);
        check("tp1_id", obs_id, 0);
        check("tp1_latency", last_lat, W + 1);

        req1_valid = 1;
        req1_din = 4'b1110;
        req1_gray_n = 1;
        run_word();
        check("tp2_dout", obs_dout, 4'b1011);
        check("tp2_id", obs_id, 1);

        for (int x = 0; x < (1 << W); x++) begin
            req0_valid = 1;
            req0_din = W'(x);
            req0_gray_n = 0;
            run_word();
            e = obs_dout;
            req1_valid = 1;
            req1_din = e;
            req1_gray_n = 1;
            run_word();
            check("roundtrip", obs_dout, x);
        end

        reset_pulse();
        w0 = words;
        for (int k = 0; k < 24; k++) begin
            if (!req0_valid) begin req0_valid = 1; req0_din = W'($urandom); req0_gray_n = 1'($urandom); end
            if (!req1_valid) begin req1_valid = 1; req1_din = W'($urandom); req1_gray_n = 1'($urandom); end
            cycle();
        end
        check("alt_words", words - w0, 4);
        check("alt_grant_count", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++) check("alt_grant_order", grants[i], i % 2);

        while (m_ph != 0 && cyc < 50000) cycle();
        req0_valid = 1;
        req1_valid = 0;
        req0_din = W'($urandom);
        req0_gray_n = 1'($urandom);
        cycle();
        cycle();
        cycle();
        EN = 0;
        repeat (3) cycle();
        EN = 1;
        run_word();
        check("stall_latency", last_lat, W + 4);

        req0_valid = 1;
        req1_valid = 1;
        req0_din = W'($urandom);
        req1_din = W'($urandom);
        out_ready = 0;
        for (int k = 0; k < 20 && m_ph != 2; k++) cycle();
        check("reach_done", m_ph, 2);
        g = grants.size();
        repeat (5) cycle();
        check("hold_no_accept", grants.size(), g);
        check("hold_out_valid", out_valid, 1);
        out_ready = 1;
        run_word();

        req0_valid = 1;
        req1_valid = 1;
        for (int k = 0; k < 20 && m_ph != 1; k++) cycle();
        check("reach_conv", m_ph, 1);
        cycle();
        cycle();
        #2;
        rst_n = 0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        model_reset();
        req0_valid = 1;
        req1_valid = 1;
        rst_n = 1;
        cycle();
        check("first_grant_after_reset", grants.size() > 0 ? grants[0] : -1, 0);

        for (int k = 0; k < 1500; k++) begin
            EN = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom);
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1; req0_din = W'($urandom); req0_gray_n = 1'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1; req1_din = W'($urandom); req1_gray_n = 1'($urandom);
            end
            cycle();
        end
        EN = 1;
        out_ready = 1;
        req0_valid = 0;
        req1_valid = 0;
        for (int k = 0; k < 20 && m_ph != 0; k++) cycle();
        check("drain_idle", m_ph, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gray_conv_sched.md
# gray_conv_sched

Two-requester scheduler that shares one bit-serial Gray encode/decode engine. It arbitrates round-robin between two valid/ready request ports and converts the granted 4-bit word MSB-first, one bit per cycle. Encode gives Dout[i] = Din[i+1]^Din[i]; decode gives Dout[i] = Dout[i+1]^Din[i]. The result is returned on a single valid/ready output port tagged with the requester id. It sits between the word producers and the Gray datapath, replacing per-requester combinational converters.

## Interface
- WIDTH, 4, word width in bits (≥2); conversion takes WIDTH cycles
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- EN  in  1  global enable; low blocks new grants and freezes an in-flight conversion
- req0_valid  in  1  requester 0 has a word
- req0_ready  out  1  requester 0 word accepted this cycle
- req0_din  in  WIDTH  requester 0 word
- req0_gray_n  in  1  requester 0 mode: 0 = binary→Gray, 1 = Gray→binary
- req1_valid / req1_ready / req1_din / req1_gray_n  same widths and meanings for requester 1
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- Dout  out  WIDTH  converted word
- out_id  out  1  requester the result belongs to
- out_gray_n  out  1  mode used for the result
- busy  out  1  high in CONV or DONE

## Operation
- The FSM has three states: IDLE, CONV and DONE.
- IDLE:
  - With EN=1 and at least one reqN_valid, the grant goes to exactly one requester, and only that requester's reqN_ready is high (combinational).
  - If one requester is valid, it gets the grant.
  - If both are valid, the grant goes to the requester named by the round-robin pointer `rr`. `rr` is 0 after reset.
  - When reqN_valid && reqN_ready, the block latches din, gray_n and id. It then goes to CONV with bit index idx = WIDTH-1.
  - With EN=0, both readies are low.
- CONV: each cycle with EN=1 produces one bit, then idx decrements.
  - idx = WIDTH-1: Dout[idx] = din[idx].
  - Otherwise, encode: Dout[idx] = din[idx+1]^din[idx].
  - Otherwise, decode: Dout[idx] = Dout[idx+1]^din[idx].
  - After bit 0 the state goes to DONE.
  - With EN=0, the state, idx and Dout hold.
- DONE:
  - out_valid=1.
  - Dout, out_id and out_gray_n are stable until handshake.
  - On out_valid && out_ready: go to IDLE and set rr = ~out_id (the other requester gets priority next).
  - EN has no effect in DONE.
- Requesters hold valid, din and gray_n stable until ready. The block samples inputs only on the handshake edge.
- Bits of Dout not yet computed in CONV are 0; they are cleared on accept. Dout is meaningful only while out_valid=1.

## Timing
- Reset (async, immediate):
  - state=IDLE, idx=WIDTH-1, rr=0.
  - Dout=0, out_valid=0, out_id=0, out_gray_n=0, busy=0.
  - Both readies low while rst_n=0.
- Reset mid-CONV or mid-DONE abandons the word. No result is emitted.
- Accept happens at edge t0. With EN held high, out_valid rises after edge t0+WIDTH.
- Each EN=0 cycle in CONV adds one cycle of latency.
- Minimum period per word is WIDTH+2 cycles: 1 IDLE + WIDTH CONV + 1 DONE, with out_ready=1.
- No request is accepted while busy=1; readies are low in CONV and DONE.
- out_ready held high while entering DONE gives the handshake in the first DONE cycle.
- reqN_ready depends combinationally on reqN_valid, EN, state and rr only. There is no path from out_ready to reqN_ready.

## Test plan
- Reset, then req0 {din=4'b1011, gray_n=0}, EN=1, out_ready=1 → req0_ready at accept. out_valid rises 4 cycles later with Dout=4'b1110, out_id=0, out_gray_n=0, for exactly 1 cycle.
- req1 {din=4'b1110, gray_n=1} → Dout=4'b1011, out_id=1. Sweep all 16 words in both modes against the formulas; decode(encode(x))=x.
- Both valid continuously from reset → grants alternate 0,1,0,1. One word per 6 cycles. Each readies pulses only in IDLE.
- Hold EN=0 for 3 cycles in mid-CONV → Dout and idx frozen, out_valid delayed exactly 3 cycles, result unchanged.
- Hold out_ready=0 for 5 cycles in DONE → out_valid, Dout and out_id stable. Both readies stay low; no new accept until the handshake.
- Pull rst_n low asynchronously mid-CONV (between edges) → all outputs zero immediately. After release, the first grant goes to req0 and no stale result appears.
